n64_vmode_switch_ctrl: RTL

Sequences video-mode changes reported by the video info extractor toward the downstream processing chain (line doubler, scaler, DAC path). A reported {vmode, n64_480i} change is applied only after it has been stable for a programmable number of frames. The change then goes through a blank/request/acknowledge handshake so downstream blocks reconfigure on a frame boundary and never see a torn frame.

---
 rtl/n64adv_vparams.sv | 21 ++
 rtl/n64_frame_tick.sv | 22 ++
 rtl/n64_vmode_switch_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/n64adv_vparams.sv
// Shared video-mode constants: vinfo bit positions, reset mode and switch FSM states.
package n64adv_vparams;

    localparam int unsigned VINFO_VMODE = 1;
    localparam int unsigned VINFO_480I  = 0;

    // NTSC, 480i
    localparam logic [1:0] MODE_RST = 2'b01;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StQualify = 2'd1,
        StReq     = 2'd2,
        StSettle  = 2'd3
    } vsw_state_e;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/n64_frame_tick.sv
// Frame boundary detector: one-cycle pulse on the nVDSYNC-qualified rising edge of nVSYNC.
module n64_frame_tick (
    input  logic VCLK,
    input  logic RST,
    input  logic nVDSYNC,
    input  logic nVSYNC,
    output logic frame_tick
);

    logic vs_prev_q;

    always_ff @(posedge VCLK or posedge RST) begin
        if (RST) begin
            vs_prev_q <= 1'b1;
        end else if (!nVDSYNC) begin
            vs_prev_q <= nVSYNC;
        end
    end

    assign frame_tick = !nVDSYNC && !vs_prev_q && nVSYNC;

endmodule

// File: rtl/n64_vmode_switch_ctrl.sv
// Video-mode switch sequencer: qualify, blank, request/ack, settle on a frame boundary.
// Define N64_VMODE_SW_TIMEOUT_EN to force the switch after ACK_TIMEOUT frames without ack.
module n64_vmode_switch_ctrl
    import n64adv_vparams::*;
#(
    parameter int unsigned STABLE_FRAMES = 3,
    parameter int unsigned ACK_TIMEOUT   = 4
) (
    input  logic       VCLK,
    input  logic       RST,
    input  logic       nVDSYNC,
    input  logic [3:0] Sync_cur,
    input  logic [3:0] vinfo_i,
    input  logic       ack_i,
    output logic [1:0] mode_o,
    output logic       blank_o,
    output logic       req_o,
    output logic       timeout_o
);

    localparam logic [3:0] STAB_N = 4'(STABLE_FRAMES);

    vsw_state_e state_q, state_d;
    logic [1:0] mode_q, mode_d, cand_q, cand_d;
    logic [3:0] stab_q, stab_d, stab_inc;
    logic       blank_q, blank_d, req_q, req_d, to_q, to_d;
    logic       go_req, frame_tick;
    logic [1:0] cand;
    logic       unused_bits;

`ifdef N64_VMODE_SW_TIMEOUT_EN
    localparam logic [3:0] ACK_N = 4'(ACK_TIMEOUT);
    logic [3:0] to_cnt_q, to_cnt_d, to_inc;
    logic       to_hit;
    assign unused_bits = ^{vinfo_i[3:2], Sync_cur[2:0]};
`else
    assign unused_bits = ^{vinfo_i[3:2], Sync_cur[2:0], 4'(ACK_TIMEOUT)};
`endif

    assign cand = {vinfo_i[VINFO_VMODE], vinfo_i[VINFO_480I]};

    n64_frame_tick u_frame_tick (
        .VCLK       (VCLK),
        .RST        (RST),
        .nVDSYNC    (nVDSYNC),
        .nVSYNC     (Sync_cur[3]),
        .frame_tick (frame_tick)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        cand_d   = cand_q;
        stab_d   = stab_q;
        blank_d  = blank_q;
        req_d    = req_q;
        to_d     = 1'b0;
        go_req   = 1'b0;
        stab_inc = sat_inc4(stab_q);
`ifdef N64_VMODE_SW_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
        to_inc   = sat_inc4(to_cnt_q);
        to_hit   = frame_tick && (to_inc == ACK_N);
`endif
        unique case (state_q)
            StIdle: begin
                if (frame_tick && (cand != mode_q)) begin
                    cand_d = cand;
                    stab_d = 4'd1;
                    if (STABLE_FRAMES == 1) go_req = 1'b1;
                    else state_d = StQualify;
                end
            end
            StQualify: begin
                if (frame_tick) begin
                    if (cand == mode_q) begin
                        state_d = StIdle;
                    end else if (cand != cand_q) begin
                        cand_d = cand;
                        stab_d = 4'd1;
                    end else begin
                        stab_d = stab_inc;
                        if (stab_inc == STAB_N) go_req = 1'b1;
                    end
                end
            end
            StReq: begin
                // ack has priority over a coincident timeout
                if (ack_i) begin
                    mode_d  = cand_q;
                    req_d   = 1'b0;
                    state_d = StSettle;
                end
`ifdef N64_VMODE_SW_TIMEOUT_EN
                else if (to_hit) begin
                    mode_d  = cand_q;
                    req_d   = 1'b0;
                    to_d    = 1'b1;
                    state_d = StSettle;
                end else if (frame_tick) begin
                    to_cnt_d = to_inc;
                end
`endif
            end
            StSettle: begin
                if (frame_tick) begin
                    state_d = StIdle;
                    blank_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (go_req) begin
            state_d = StReq;
            blank_d = 1'b1;
            req_d   = 1'b1;
`ifdef N64_VMODE_SW_TIMEOUT_EN
            to_cnt_d = 4'd0;
`endif
        end
    end

    always_ff @(posedge VCLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            mode_q  <= MODE_RST;
            cand_q  <= 2'b00;
            stab_q  <= 4'd0;
            blank_q <= 1'b0;
            req_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cand_q  <= cand_d;
            stab_q  <= stab_d;
            blank_q <= blank_d;
            req_q   <= req_d;
            to_q    <= to_d;
        end
    end

`ifdef N64_VMODE_SW_TIMEOUT_EN
    always_ff @(posedge VCLK or posedge RST) begin
        if (RST) to_cnt_q <= 4'd0;
        else     to_cnt_q <= to_cnt_d;
    end
`endif

    assign mode_o    = mode_q;
    assign blank_o   = blank_q;
    assign req_o     = req_q;
    assign timeout_o = to_q;

endmodule
